multdiv_issue_ctrl: RTL and testbench
=====================================

// Module: multdiv_issue_ctrl
// PURPOSE
//  Sequences the multi-cycle multiplier/divider for the 5-stage pipeline. It detects a mult or div
//  in the DX stage and issues a one-cycle start pulse to the multdiv unit. It holds PC/FD/DX stalled
//  until the result is ready, then hands the result and its writeback target to the XM latch.
//  Exceptions and timeouts are converted to an $rstatus write (reg 30).
// PARAMETERS
//  MAX_CYCLES   40   cycles after the start pulse before an op with no ready is declared timed out
//  CNT_W        6    busy counter width; must satisfy 2**CNT_W > MAX_CYCLES
//  MULT_EXC     4    value written to $rstatus on mult exception or timeout
//  DIV_EXC      5    value written to $rstatus on div exception or timeout
// PORTS
//  clock          in   1   rising-edge clock
//  reset_n        in   1   asynchronous, active-low reset
//  dx_instr       in   32  instruction currently in the DX latch
//  dx_valid       in   1   DX holds a real (non-bubble) instruction
//  flush          in   1   squash the DX-stage op (interrupt/redirect); aborts an in-flight op
//  md_ready       in   1   multdiv data_resultRDY
//  md_exception   in   1   multdiv data_exception, valid with md_ready
//  md_result      in   32  multdiv data_result, valid with md_ready
//  ctrl_mult      out  1   one-cycle start pulse to multdiv (multiply)
//  ctrl_div       out  1   one-cycle start pulse to multdiv (divide)
//  stall          out  1   hold PC, FD and DX latches; insert bubble into XM
//  wb_valid       out  1   one cycle: XM must capture wb_value/wb_rd/wb_we
//  wb_value       out  32  result, or MULT_EXC/DIV_EXC on exception/timeout
//  wb_rd          out  5   destination: instr[26:22], or 5'd30 on exception/timeout
//  wb_we          out  1   register write enable for this result
// BEHAVIOUR
//  - Decode: is_md = dx_valid & (instr[31:27]==5'b00000) & (instr[6:2] is 5'b00110 mult or 5'b00111 div).
//  - FSM states are IDLE, BUSY and DONE. Reset puts the FSM in IDLE. All outputs reset to 0, counter to 0.
//  - IDLE: stall = is_md & ~flush (combinational, same cycle as detection).
//    If that condition is true: latch op type and rd, assert ctrl_mult/ctrl_div (registered) and go to BUSY.
//  - BUSY: stall = 1 and counter increments.
//    The first BUSY cycle is the start-pulse cycle; md_ready in that cycle is ignored because it belongs to a prior op.
//    md_ready in a later cycle: capture result/exception, go to DONE.
//    Counter reaching MAX_CYCLES with no ready: record a timeout exception, go to DONE.
//  - DONE: stall = 0 and wb_valid = 1 for exactly one cycle, and the DX instruction advances at this edge.
//    Detection is suppressed in DONE so the same op is not reissued. Next state is IDLE.
//  - Latency: detect at T, pulse at T+1, ready at T+1+k (k>=1), wb_valid at T+2+k.
//    Stall is high from T through T+1+k.
//  - Writeback selection:
//    exception/timeout -> wb_value = MULT_EXC or DIV_EXC (by op), wb_rd = 30, wb_we = 1.
//    otherwise -> wb_value = md_result, wb_rd = latched rd, wb_we = (rd != 0).
//  - flush in IDLE: no issue. flush in BUSY: go to IDLE next cycle, deassert stall, no wb_valid.
//    A late md_ready after an abort is ignored.
//  - A flush in DONE has no effect, because the result has already been handed off.
//  - Back-to-back mult/div: the second op is detected in the IDLE cycle after DONE, so there is one idle cycle between them.
//  - Reset mid-op: immediate return to IDLE with stall = 0. The multdiv unit is restarted by the next pulse.
//  - ctrl_mult and ctrl_div are never high together, and each is never high for 2 consecutive cycles.
// STRUCTURE
//  - The opcode/ALU-op constants (ALU opcode, MULT/DIV ALU-ops, RSTATUS reg number) go in the shared ISA
//    header used by the other decode/control blocks. The FSM state encoding stays local.
//  - No sub-module. The busy counter is inline; the decode reuses the shared decoder32.
// TESTING
//  1 mult $5,$3,$4 with ($3=3,$4=4), ready 32 cycles after the pulse
//    -> stall high for 34 cycles, then wb_valid=1, wb_value=12, wb_rd=5, wb_we=1.
//  2 div $6,$1,$2 with divisor 0, ready+exception after 1 cycle -> wb_value=5, wb_rd=30, wb_we=1.
//  3 mult $0,$1,$2 -> wb_valid=1, wb_we=0. Ready asserted in the pulse cycle -> ignored, FSM stays BUSY.
//  4 ready never asserted -> timeout after 40 BUSY cycles, then wb_value=4, wb_rd=30, stall drops.
//  5 flush on the 3rd BUSY cycle, then ready 5 cycles later
//    -> no wb_valid, stall=0 the cycle after flush. reset_n low mid-BUSY -> outputs 0 asynchronously.
//  6 Back-to-back mult then div -> exactly one ctrl_mult pulse, then one ctrl_div pulse.
//    The div pulse is 2 cycles after the mult's wb_valid.

Source files
------------

// File: rtl/multdiv_issue_ctrl_pkg.sv
// Shared ISA constants and decode helper for the multdiv issue controller.
// Fields follow the R-type layout: opcode[31:27] rd[26:22] rs[21:17] rt[16:12] shamt[11:7] aluop[6:2].
package multdiv_issue_ctrl_pkg;

   localparam logic [4:0] OPC_ALU     = 5'b00000;
   localparam logic [4:0] ALUOP_MULT  = 5'b00110;
   localparam logic [4:0] ALUOP_DIV   = 5'b00111;
   localparam logic [4:0] REG_RSTATUS = 5'd30;

   localparam int          MD_MAX_CYCLES = 40;
   localparam int          MD_CNT_W      = 6;
   localparam logic [31:0] MD_MULT_EXC   = 32'd4;
   localparam logic [31:0] MD_DIV_EXC    = 32'd5;

   typedef enum logic {OP_MULT = 1'b0, OP_DIV = 1'b1} md_op_e;

   typedef struct packed {
      logic   is_md;
      md_op_e op;
      logic [4:0] rd;
   } md_dec_t;

   function automatic md_dec_t md_decode(input logic [31:0] instr, input logic vld);
      md_dec_t d;
      d.is_md = vld && (instr[31:27] == OPC_ALU) &&
                ((instr[6:2] == ALUOP_MULT) || (instr[6:2] == ALUOP_DIV));
      d.op    = (instr[6:2] == ALUOP_DIV) ? OP_DIV : OP_MULT;
      d.rd    = instr[26:22];
      return d;
   endfunction

endpackage

// File: rtl/multdiv_issue_ctrl_if.sv
// DX-stage / multdiv / XM-writeback signal bundle for the multdiv issue controller.
// master = controller side, slave = pipeline and multdiv side.
interface multdiv_issue_ctrl_if;
   logic [31:0] dx_instr;
   logic        dx_valid;
   logic        flush;
   logic        md_ready;
   logic        md_exception;
   logic [31:0] md_result;
   logic        ctrl_mult;
   logic        ctrl_div;
   logic        stall;
   logic        wb_valid;
   logic [31:0] wb_value;
   logic [4:0]  wb_rd;
   logic        wb_we;

   modport master (
      input  dx_instr, dx_valid, flush, md_ready, md_exception, md_result,
      output ctrl_mult, ctrl_div, stall, wb_valid, wb_value, wb_rd, wb_we
   );

   modport slave (
      output dx_instr, dx_valid, flush, md_ready, md_exception, md_result,
      input  ctrl_mult, ctrl_div, stall, wb_valid, wb_value, wb_rd, wb_we
   );
endinterface

// File: rtl/multdiv_issue_ctrl.sv
// Issues mult/div from DX to the multdiv unit, stalls the front end, hands the result to XM.
// Latency: detect T, start pulse T+1, ready T+1+k, wb_valid T+2+k.
// Backpressure: stall held from detection until the ready cycle; flush aborts, timeout writes $rstatus.
module multdiv_issue_ctrl
   import multdiv_issue_ctrl_pkg::*;
#(
   parameter int          MAX_CYCLES = MD_MAX_CYCLES,
   parameter int          CNT_W      = MD_CNT_W,
   parameter logic [31:0] MULT_EXC   = MD_MULT_EXC,
   parameter logic [31:0] DIV_EXC    = MD_DIV_EXC
)(
   input logic                 clock,
   input logic                 reset_n,
   multdiv_issue_ctrl_if.master bus
);

   typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_BUSY = 2'd1, ST_DONE = 2'd2} state_e;

   state_e            state_q;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   md_op_e            op_q;
   logic [4:0]        rd_q;
   logic              ctrl_mult_q, ctrl_div_q;
   logic              wb_valid_q, wb_we_q;
   logic [31:0]       wb_value_q;
   logic [4:0]        wb_rd_q;

   md_dec_t dec;
   logic    issue, first_busy, timeout;

   always_comb begin
      dec        = md_decode(bus.dx_instr, bus.dx_valid);
      issue      = (state_q == ST_IDLE) && dec.is_md && !bus.flush;
      cnt_d      = cnt_q + 1'b1;
      first_busy = (cnt_q == '0);
      timeout    = (cnt_d == CNT_W'(MAX_CYCLES));
   end

   // Gated by reset_n so the front end is released as soon as reset asserts.
   assign bus.stall     = reset_n && (issue || (state_q == ST_BUSY));
   assign bus.ctrl_mult = ctrl_mult_q;
   assign bus.ctrl_div  = ctrl_div_q;
   assign bus.wb_valid  = wb_valid_q;
   assign bus.wb_value  = wb_value_q;
   assign bus.wb_rd     = wb_rd_q;
   assign bus.wb_we     = wb_we_q;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         op_q        <= OP_MULT;
         rd_q        <= '0;
         ctrl_mult_q <= 1'b0;
         ctrl_div_q  <= 1'b0;
         wb_valid_q  <= 1'b0;
         wb_we_q     <= 1'b0;
         wb_value_q  <= '0;
         wb_rd_q     <= '0;
      end else begin
         ctrl_mult_q <= 1'b0;
         ctrl_div_q  <= 1'b0;
         wb_valid_q  <= 1'b0;
         wb_we_q     <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (issue) begin
                  op_q        <= dec.op;
                  rd_q        <= dec.rd;
                  cnt_q       <= '0;
                  ctrl_mult_q <= (dec.op == OP_MULT);
                  ctrl_div_q  <= (dec.op == OP_DIV);
                  state_q     <= ST_BUSY;
               end
            end
            ST_BUSY: begin
               cnt_q <= cnt_d;
               if (bus.flush) begin
                  state_q <= ST_IDLE;
               // A ready seen alongside the start pulse belongs to an earlier op.
               end else if (!first_busy && bus.md_ready) begin
                  state_q    <= ST_DONE;
                  wb_valid_q <= 1'b1;
                  if (bus.md_exception) begin
                     wb_value_q <= (op_q == OP_DIV) ? DIV_EXC : MULT_EXC;
                     wb_rd_q    <= REG_RSTATUS;
                     wb_we_q    <= 1'b1;
                  end else begin
                     wb_value_q <= bus.md_result;
                     wb_rd_q    <= rd_q;
                     wb_we_q    <= (rd_q != 5'd0);
                  end
               end else if (timeout) begin
                  state_q    <= ST_DONE;
                  wb_valid_q <= 1'b1;
                  wb_value_q <= (op_q == OP_DIV) ? DIV_EXC : MULT_EXC;
                  wb_rd_q    <= REG_RSTATUS;
                  wb_we_q    <= 1'b1;
               end
            end
            ST_DONE: state_q <= ST_IDLE;
            default: state_q <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_multdiv_issue_ctrl.sv
// Directed bench for multdiv_issue_ctrl; expected writebacks are queued at issue and popped by a monitor.
module tb_multdiv_issue_ctrl;
   import multdiv_issue_ctrl_pkg::*;

   logic clock = 1'b0;
   logic reset_n = 1'b0;
   always #5 clock = ~clock;

   multdiv_issue_ctrl_if bus();

   multdiv_issue_ctrl dut (
      .clock   (clock),
      .reset_n (reset_n),
      .bus     (bus)
   );

   typedef struct packed {
      logic [31:0] value;
      logic [4:0]  rd;
      logic        we;
   } wb_t;

   wb_t exp_q[$];
   int  total = 0;
   int  bad = 0;
   int  cyc = 0;
   int  wb_cyc = -1;
   int  div_pulse_cyc = -1;
   int  mult_pulses = 0;
   int  div_pulses = 0;
   logic prev_m = 1'b0;
   logic prev_d = 1'b0;

   always @(posedge clock) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   function automatic logic [31:0] mk(input logic [4:0] rd, input logic [4:0] rs,
                                      input logic [4:0] rt, input logic [4:0] aluop);
      return {OPC_ALU, rd, rs, rt, 5'b00000, aluop, 2'b00};
   endfunction

   // Writeback scoreboard and start-pulse monitor.
   always @(negedge clock) begin
      wb_t e;
      if (reset_n && bus.wb_valid) begin
         wb_cyc = cyc;
         if (exp_q.size() == 0) begin
            chk("unexpected_wb_valid", 32'd1, 32'd0);
         end else begin
            e = exp_q.pop_front();
            chk("wb_value", bus.wb_value, e.value);
            chk("wb_rd", {27'd0, bus.wb_rd}, {27'd0, e.rd});
            chk("wb_we", {31'd0, bus.wb_we}, {31'd0, e.we});
         end
      end
      if (reset_n && (bus.ctrl_mult || bus.ctrl_div)) begin
         chk("pulse_exclusive", {31'd0, bus.ctrl_mult & bus.ctrl_div}, 32'd0);
         chk("pulse_single_cycle", {31'd0, (bus.ctrl_mult & prev_m) | (bus.ctrl_div & prev_d)}, 32'd0);
         if (bus.ctrl_mult) mult_pulses++;
         if (bus.ctrl_div) begin
            div_pulses++;
            div_pulse_cyc = cyc;
         end
      end
      prev_m = bus.ctrl_mult;
      prev_d = bus.ctrl_div;
   end

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   // Drives one op from detection to writeback; k = cycles from pulse to ready.
   task automatic do_op(input logic [31:0] instr, input int k, input logic exc,
                        input logic [31:0] res, input logic early, input logic exp_mult,
                        input int exp_stall, input logic [31:0] nxt, input logic nxt_vld,
                        input string nm);
      int   stalls = 0;
      logic seen = 1'b0;
      bus.dx_instr = instr;
      bus.dx_valid = 1'b1;
      bus.flush    = 1'b0;
      for (int c = 0; c < 80 && !seen; c++) begin
         bus.md_ready     = (c == 1 + k) || (early && c == 1);
         bus.md_exception = exc && (c == 1 + k);
         bus.md_result    = (c == 1 + k) ? res : 32'hDEAD_BEEF;
         @(negedge clock);
         if (bus.stall) stalls++;
         if (c == 1) begin
            chk({nm, "_ctrl_mult"}, {31'd0, bus.ctrl_mult}, {31'd0, exp_mult});
            chk({nm, "_ctrl_div"}, {31'd0, bus.ctrl_div}, {31'd0, !exp_mult});
         end
         if (bus.wb_valid) seen = 1'b1;
         step();
      end
      bus.md_ready     = 1'b0;
      bus.md_exception = 1'b0;
      bus.dx_instr     = nxt;
      bus.dx_valid     = nxt_vld;
      chk({nm, "_wb_seen"}, {31'd0, seen}, 32'd1);
      chk({nm, "_stall_cycles"}, stalls, exp_stall);
   endtask

   initial begin
      int w;
      int m0;
      int d0;
      bus.dx_instr     = '0;
      bus.dx_valid     = 1'b0;
      bus.flush        = 1'b0;
      bus.md_ready     = 1'b0;
      bus.md_exception = 1'b0;
      bus.md_result    = '0;
      reset_n          = 1'b0;
      #12;
      chk("rst_stall", {31'd0, bus.stall}, 32'd0);
      chk("rst_ctrl_mult", {31'd0, bus.ctrl_mult}, 32'd0);
      chk("rst_ctrl_div", {31'd0, bus.ctrl_div}, 32'd0);
      chk("rst_wb_valid", {31'd0, bus.wb_valid}, 32'd0);
      chk("rst_wb_we", {31'd0, bus.wb_we}, 32'd0);
      @(posedge clock);
      #2 reset_n = 1'b1;
      step();

      // mult $5,$3,$4 = 12, ready 32 cycles after the pulse
      exp_q.push_back(wb_t'{32'd12, 5'd5, 1'b1});
      do_op(mk(5'd5, 5'd3, 5'd4, ALUOP_MULT), 32, 1'b0, 32'd12, 1'b0, 1'b1, 34, '0, 1'b0, "t1");
      step();

      // div $6,$1,$2 by zero -> $rstatus = 5
      exp_q.push_back(wb_t'{32'd5, 5'd30, 1'b1});
      do_op(mk(5'd6, 5'd1, 5'd2, ALUOP_DIV), 1, 1'b1, 32'd0, 1'b0, 1'b0, 3, '0, 1'b0, "t2");
      step();

      // mult $0 with a stale ready in the pulse cycle
      exp_q.push_back(wb_t'{32'h77, 5'd0, 1'b0});
      do_op(mk(5'd0, 5'd1, 5'd2, ALUOP_MULT), 3, 1'b0, 32'h77, 1'b1, 1'b1, 5, '0, 1'b0, "t3");
      step();

      // no ready at all -> timeout
      exp_q.push_back(wb_t'{32'd4, 5'd30, 1'b1});
      do_op(mk(5'd7, 5'd1, 5'd2, ALUOP_MULT), 1000, 1'b0, 32'd0, 1'b0, 1'b1, 41, '0, 1'b0, "t4");
      step();

      // flush on the 3rd BUSY cycle, late ready afterwards
      bus.dx_instr = mk(5'd6, 5'd1, 5'd2, ALUOP_DIV);
      bus.dx_valid = 1'b1;
      for (int c = 0; c < 12; c++) begin
         bus.flush    = (c == 3);
         bus.md_ready = (c == 8);
         if (c >= 4) bus.dx_valid = 1'b0;
         @(negedge clock);
         if (c == 3) chk("flush_cycle_stall", {31'd0, bus.stall}, 32'd1);
         if (c == 4) chk("stall_after_flush", {31'd0, bus.stall}, 32'd0);
         if (c == 9) chk("stall_after_late_ready", {31'd0, bus.stall}, 32'd0);
         step();
      end
      bus.flush    = 1'b0;
      bus.md_ready = 1'b0;

      // asynchronous reset in the start-pulse cycle
      bus.dx_instr = mk(5'd5, 5'd3, 5'd4, ALUOP_MULT);
      bus.dx_valid = 1'b1;
      @(negedge clock);
      chk("t5r_detect_stall", {31'd0, bus.stall}, 32'd1);
      step();
      @(negedge clock);
      chk("t5r_pulse", {31'd0, bus.ctrl_mult}, 32'd1);
      #2 reset_n = 1'b0;
      #1;
      chk("t5r_async_stall", {31'd0, bus.stall}, 32'd0);
      chk("t5r_async_ctrl", {31'd0, bus.ctrl_mult}, 32'd0);
      chk("t5r_async_wb_valid", {31'd0, bus.wb_valid}, 32'd0);
      bus.dx_valid = 1'b0;
      @(posedge clock);
      #2 reset_n = 1'b1;
      step();

      // back-to-back mult then div
      m0 = mult_pulses;
      d0 = div_pulses;
      exp_q.push_back(wb_t'{32'd6, 5'd8, 1'b1});
      exp_q.push_back(wb_t'{32'd3, 5'd9, 1'b1});
      do_op(mk(5'd8, 5'd2, 5'd3, ALUOP_MULT), 2, 1'b0, 32'd6, 1'b0, 1'b1, 4,
            mk(5'd9, 5'd6, 5'd2, ALUOP_DIV), 1'b1, "t6m");
      w = wb_cyc;
      do_op(mk(5'd9, 5'd6, 5'd2, ALUOP_DIV), 3, 1'b0, 32'd3, 1'b0, 1'b0, 5, '0, 1'b0, "t6d");
      chk("t6_mult_pulses", mult_pulses - m0, 32'd1);
      chk("t6_div_pulses", div_pulses - d0, 32'd1);
      chk("t6_div_pulse_gap", div_pulse_cyc - w, 32'd2);
      repeat (3) step();

      chk("queue_empty", exp_q.size(), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
